// File: rtl/a2bus_read_responder.sv
// Apple II read-cycle responder: arbitrates internal claimants and sequences the
// FPGA data-bus drive (output enable, data, hold after Phi0 fall, watchdog release).
module a2bus_read_responder #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned CLAIM_COUNT = 4,
   parameter int unsigned DRIVE_START = 6,
   parameter int unsigned HOLD_COUNT  = 2,
   parameter int unsigned MAX_DRIVE   = 40
) (
   input  logic                 clk_logic_i,
   input  logic                 system_reset_n_i,
   input  logic                 enable_i,
   input  logic                 phi0_posedge_i,
   input  logic                 phi0_negedge_i,
   input  logic                 rw_n_i,
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [NUM_REQ*8-1:0] req_data_i,
   output logic [NUM_REQ-1:0]   grant_o,
   output logic [7:0]           d_o,
   output logic                 d_oe_o,
   output logic                 busy_o,
   output logic                 conflict_o,
   output logic [7:0]           conflict_count_o
);

   localparam int unsigned HoldW = (HOLD_COUNT > 1) ? $clog2(HOLD_COUNT) : 1;

   if (!(CLAIM_COUNT >= 1 && CLAIM_COUNT < DRIVE_START && DRIVE_START < MAX_DRIVE &&
         MAX_DRIVE <= 63 && HOLD_COUNT >= 1)) begin : g_param_check
      $error("a2bus_read_responder: invalid timing parameters");
   end

   typedef enum logic [2:0] {
      StIdle,
      StClaim,
      StWaitDrive,
      StDrive,
      StHold
   } state_e;

   state_e             state_q;
   logic [5:0]         cnt_q;
   logic [HoldW-1:0]   hold_cnt_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [7:0]         d_q;
   logic               d_oe_q;
   logic               conflict_q;
   logic [7:0]         conflict_count_q;

   logic [NUM_REQ-1:0] req_first;
   logic               req_multi;
   logic [7:0]         sel_data;

   // Lowest set bit wins; more than one bit set means a conflict.
   assign req_first = req_i & (~req_i + NUM_REQ'(1));
   assign req_multi = (req_i & (req_i - NUM_REQ'(1))) != '0;

   always_comb begin
      sel_data = 8'h00;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_q[k]) begin
            sel_data = sel_data | req_data_i[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
      if (!system_reset_n_i) begin
         state_q          <= StIdle;
         cnt_q            <= 6'd0;
         hold_cnt_q       <= '0;
         grant_q          <= '0;
         d_q              <= 8'h00;
         d_oe_q           <= 1'b0;
         conflict_q       <= 1'b0;
         conflict_count_q <= 8'h00;
      end else begin
         conflict_q <= 1'b0;

         if (phi0_posedge_i) begin
            cnt_q <= 6'd1;
         end else if (cnt_q != 6'd63) begin
            cnt_q <= cnt_q + 6'd1;
         end

         if (!enable_i) begin
            state_q <= StIdle;
            d_oe_q  <= 1'b0;
            grant_q <= '0;
         end else if (phi0_posedge_i) begin
            // A new bus cycle always ends any response still in flight.
            d_oe_q  <= 1'b0;
            grant_q <= '0;
            state_q <= rw_n_i ? StClaim : StIdle;
         end else begin
            unique case (state_q)
               StIdle: begin
               end

               StClaim: begin
                  if (phi0_negedge_i) begin
                     state_q <= StIdle;
                     grant_q <= '0;
                  end else if (req_i != '0) begin
                     grant_q <= req_first;
                     state_q <= StWaitDrive;
                     if (req_multi) begin
                        conflict_q <= 1'b1;
                        if (conflict_count_q != 8'hFF) begin
                           conflict_count_q <= conflict_count_q + 8'd1;
                        end
                     end
                  end else if (cnt_q == 6'(CLAIM_COUNT)) begin
                     state_q <= StIdle;
                  end
               end

               StWaitDrive: begin
                  if (phi0_negedge_i) begin
                     state_q <= StIdle;
                     grant_q <= '0;
                  end else begin
                     d_q <= sel_data;
                     if (cnt_q == 6'(DRIVE_START)) begin
                        state_q <= StDrive;
                        d_oe_q  <= 1'b1;
                     end
                  end
               end

               StDrive: begin
                  if (phi0_negedge_i) begin
                     state_q    <= StHold;
                     hold_cnt_q <= '0;
                  end else if (cnt_q == 6'(MAX_DRIVE)) begin
                     state_q <= StIdle;
                     d_oe_q  <= 1'b0;
                     grant_q <= '0;
                  end else begin
                     d_q <= sel_data;
                  end
               end

               StHold: begin
                  if (hold_cnt_q == HoldW'(HOLD_COUNT - 1)) begin
                     state_q <= StIdle;
                     d_oe_q  <= 1'b0;
                     grant_q <= '0;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + HoldW'(1);
                  end
               end

               default: begin
                  state_q <= StIdle;
                  d_oe_q  <= 1'b0;
                  grant_q <= '0;
               end
            endcase
         end
      end
   end

   assign grant_o          = grant_q;
   assign d_o              = d_q;
   assign d_oe_o           = d_oe_q;
   assign busy_o           = (state_q != StIdle);
   assign conflict_o       = conflict_q;
   assign conflict_count_o = conflict_count_q;

endmodule

// File: tb/tb_a2bus_read_responder.sv
// Scoreboard bench for a2bus_read_responder: stimulus pushes expected drives and
// conflict counts, a negedge monitor pops and compares them as the DUT produces them.
module tb_a2bus_read_responder;

   typedef struct {
      logic [3:0] grant;
      logic [7:0] data;
      int         len;
   } drive_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        phi0_pos;
   logic        phi0_neg;
   logic        rw_n;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  grant;
   logic [7:0]  d;
   logic        d_oe;
   logic        busy;
   logic        conflict;
   logic [7:0]  conflict_count;

   int          vectors = 0;
   int          errors  = 0;
   drive_t      exp_q[$];
   logic [7:0]  conf_q[$];
   drive_t      cur;
   bit          cur_valid = 1'b0;
   bit          in_drive  = 1'b0;
   int          run_len   = 0;
   bit          busy_seen = 1'b0;
   bit          grant_seen = 1'b0;
   logic [7:0]  conf_exp;

   always #5 clk = ~clk;

   a2bus_read_responder dut (
      .clk_logic_i      (clk),
      .system_reset_n_i (rst_n),
      .enable_i         (enable),
      .phi0_posedge_i   (phi0_pos),
      .phi0_negedge_i   (phi0_neg),
      .rw_n_i           (rw_n),
      .req_i            (req),
      .req_data_i       (req_data),
      .grant_o          (grant),
      .d_o              (d),
      .d_oe_o           (d_oe),
      .busy_o           (busy),
      .conflict_o       (conflict),
      .conflict_count_o (conflict_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (busy === 1'b1) busy_seen = 1'b1;
      if (grant !== 4'b0000) grant_seen = 1'b1;
      if (d_oe === 1'b1 && !in_drive) begin
         in_drive = 1'b1;
         run_len  = 1;
         if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            cur_valid = 1'b0;
            $display("FAIL unexpected_drive: got d_oe=1 grant=%b, required no drive (t=%0t)",
                     grant, $time);
         end else begin
            cur       = exp_q.pop_front();
            cur_valid = 1'b1;
            check("drive_grant", 32'(grant), 32'(cur.grant));
            check("drive_data", 32'(d), 32'(cur.data));
         end
      end else if (d_oe === 1'b1) begin
         run_len++;
      end else if (in_drive) begin
         in_drive = 1'b0;
         if (cur_valid) begin
            check("drive_length", 32'(run_len), 32'(cur.len));
            check("release_grant", 32'(grant), 32'd0);
         end
      end
      if (conflict === 1'b1) begin
         if (conf_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_conflict: got conflict pulse, required none (t=%0t)",
                     $time);
         end else begin
            conf_exp = conf_q.pop_front();
            check("conflict_count", 32'(conflict_count), 32'(conf_exp));
         end
      end
   end

   task automatic clear_inputs();
      phi0_pos = 1'b0;
      phi0_neg = 1'b0;
      rw_n     = 1'b1;
      req      = 4'b0000;
      enable   = 1'b1;
   endtask

   task automatic idle(input int n);
      clear_inputs();
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Cycle k of a bus cycle sees cnt == k; -1 disables an event.
   task automatic bus_cycle(input logic rw, input logic [3:0] r, input int req_at,
                            input int neg_at, input int pos2_at, input int en_low_at,
                            input int total);
      for (int k = 0; k < total; k++) begin
         phi0_pos = (k == 0) || (k == pos2_at);
         phi0_neg = (k == neg_at);
         rw_n     = rw;
         req      = (req_at >= 0 && k >= req_at) ? r : 4'b0000;
         enable   = (k == en_low_at) ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
      end
      clear_inputs();
   endtask

   initial begin
      rst_n    = 1'b0;
      req_data = 32'h0;
      clear_inputs();
      #1;
      check("rst_d_oe", 32'(d_oe), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_d", 32'(d), 32'd0);
      check("rst_conflict_count", 32'(conflict_count), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);
      check("idle_busy", 32'(busy), 32'd0);

      // Single claim at cnt=2
      req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
      exp_q.push_back('{grant: 4'b0100, data: 8'hA5, len: 16});
      bus_cycle(1'b1, 4'b0100, 2, 20, -1, -1, 26);
      check("single_busy_after", 32'(busy), 32'd0);
      check("single_d_held", 32'(d), 32'hA5);
      check("single_no_conflict", 32'(conflict_count), 32'd0);
      idle(3);

      // Write cycle must never leave idle
      busy_seen = 1'b0;
      bus_cycle(1'b0, 4'b0001, 0, 10, -1, -1, 16);
      check("write_busy_seen", 32'(busy_seen), 32'd0);
      idle(3);

      // Claim first raised after the claim window
      grant_seen = 1'b0;
      bus_cycle(1'b1, 4'b0001, 5, 12, -1, -1, 16);
      check("late_grant_seen", 32'(grant_seen), 32'd0);
      check("late_busy", 32'(busy), 32'd0);
      idle(3);

      // Watchdog: no negedge
      req_data = {8'h44, 8'h33, 8'h22, 8'h5A};
      exp_q.push_back('{grant: 4'b0001, data: 8'h5A, len: 34});
      bus_cycle(1'b1, 4'b0001, 1, -1, -1, -1, 50);
      check("wdog_busy", 32'(busy), 32'd0);
      check("wdog_grant", 32'(grant), 32'd0);
      idle(3);

      // Negedge abort in WAIT_DRIVE
      bus_cycle(1'b1, 4'b0001, 1, 3, -1, -1, 10);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_grant", 32'(grant), 32'd0);
      idle(3);

      // Posedge during DRIVE restarts a claim
      req_data = {8'hC3, 8'h33, 8'h22, 8'h11};
      exp_q.push_back('{grant: 4'b1000, data: 8'hC3, len: 9});
      exp_q.push_back('{grant: 4'b1000, data: 8'hC3, len: 6});
      bus_cycle(1'b1, 4'b1000, 1, 25, 15, -1, 30);
      check("restart_busy", 32'(busy), 32'd0);
      idle(3);

      // Conflicts, up to saturation
      req_data = {8'h77, 8'h66, 8'h3C, 8'h55};
      exp_q.push_back('{grant: 4'b0010, data: 8'h3C, len: 4});
      conf_q.push_back(8'd1);
      bus_cycle(1'b1, 4'b1010, 1, 8, -1, -1, 12);
      check("conflict_first", 32'(conflict_count), 32'd1);
      for (int i = 2; i <= 256; i++) begin
         exp_q.push_back('{grant: 4'b0010, data: 8'h3C, len: 4});
         conf_q.push_back((i > 255) ? 8'd255 : 8'(i));
         bus_cycle(1'b1, 4'b1010, 1, 8, -1, -1, 12);
      end
      check("conflict_saturated", 32'(conflict_count), 32'd255);
      idle(3);

      // enable low during HOLD
      req_data = {8'h77, 8'h66, 8'h9E, 8'h55};
      exp_q.push_back('{grant: 4'b0010, data: 8'h9E, len: 5});
      bus_cycle(1'b1, 4'b0010, 1, 10, -1, 11, 16);
      check("enable_busy", 32'(busy), 32'd0);
      check("enable_count_kept", 32'(conflict_count), 32'd255);
      idle(3);

      // Asynchronous reset in DRIVE
      req_data = {8'h77, 8'hE1, 8'h22, 8'h55};
      exp_q.push_back('{grant: 4'b0100, data: 8'hE1, len: 5});
      bus_cycle(1'b1, 4'b0100, 1, -1, -1, -1, 12);
      check("pre_reset_d_oe", 32'(d_oe), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_d_oe", 32'(d_oe), 32'd0);
      check("async_rst_grant", 32'(grant), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_count", 32'(conflict_count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(4);

      check("drive_queue_drained", 32'(exp_q.size()), 32'd0);
      check("conflict_queue_drained", 32'(conf_q.size()), 32'd0);
      check("no_open_drive", 32'(in_drive), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/a2bus_read_responder.md
Name: a2bus_read_responder

Overview:
- Arbitrates among NUM_REQ internal slot/card functions that want to answer the current Apple II read cycle.
- Sequences the timing of the FPGA's data-bus drive: output enable, data, and hold after Phi0 falls.
- Sits between the a2bus_if timing strobes (phi0 edges, sampled rw_n) and the board's data-bus output buffer.
- Card modules only raise a claim and present a byte. All bus-drive timing lives here.

Parameters:
- NUM_REQ, 4: number of requesters; index 0 has the highest priority.
- CLAIM_COUNT, 4: number of clk cycles after phi0_posedge during which claims are accepted.
- DRIVE_START, 6: cycle count after phi0_posedge at which drive begins (~111 ns at 54 MHz).
- HOLD_COUNT, 2: clk cycles the drive is held after phi0_negedge.
- MAX_DRIVE, 40: watchdog cycle count after phi0_posedge; drive is force-released if no phi0_negedge arrives.

Ports:
- clk_logic_i, in, 1: logic clock; the only clock.
- system_reset_n_i, in, 1: reset, asynchronous, active-low.
- enable_i, in, 1: responder enable.
- phi0_posedge_i, in, 1: single-cycle strobe at Phi0 rise.
- phi0_negedge_i, in, 1: single-cycle strobe at Phi0 fall.
- rw_n_i, in, 1: bus R/W_n as latched during Phi1; valid at phi0_posedge.
- req_i, in, NUM_REQ: claim of the current read cycle, one bit per requester.
- req_data_i, in, NUM_REQ*8: byte from requester k on bits [8k+7:8k].
- grant_o, out, NUM_REQ: one-hot grant, held for the whole response.
- d_o, out, 8: data to the bus output buffer.
- d_oe_o, out, 1: data-bus output enable, active high.
- busy_o, out, 1: high whenever state != IDLE.
- conflict_o, out, 1: one-cycle pulse when more than one req_i bit is set at the grant cycle.
- conflict_count_o, out, 8: saturating count of conflicts.

Behaviour:
- Reset values: all outputs 0; state IDLE; cnt 0. Reset asserted mid-drive drops d_oe_o and grant_o asynchronously.
- cnt is a 6-bit counter. It is loaded with 1 on the cycle after phi0_posedge_i and increments every cycle, saturating at 63.
- Required parameter relations, checked at elaboration: 1 <= CLAIM_COUNT < DRIVE_START < MAX_DRIVE <= 63; HOLD_COUNT >= 1.
- IDLE:
  - On phi0_posedge_i with enable_i=1 and rw_n_i=1, go to CLAIM.
  - Write cycles (rw_n_i=0) never leave IDLE.
- CLAIM:
  - Each cycle with req_i != 0: grant_o <= lowest set index; go to WAIT_DRIVE.
  - If popcount(req_i) > 1 on that cycle: pulse conflict_o and increment conflict_count_o, saturating at 255.
  - If cnt == CLAIM_COUNT and req_i == 0: go to IDLE. Later claims are ignored until the next phi0_posedge.
- WAIT_DRIVE:
  - d_o <= granted requester's byte every cycle.
  - When cnt == DRIVE_START: go to DRIVE; d_oe_o <= 1 (registered, so it rises on the following edge).
- DRIVE:
  - d_o keeps tracking the granted byte, so late data is allowed.
  - On phi0_negedge_i: go to HOLD; d_o freezes; hold counter cleared.
  - If cnt == MAX_DRIVE before any negedge: go to IDLE; d_oe_o <= 0; grant cleared.
- HOLD:
  - d_oe_o stays 1 and d_o is frozen.
  - After HOLD_COUNT cycles: go to IDLE; d_oe_o <= 0; grant_o <= 0.
- d_oe_o is 1 only in DRIVE and HOLD.
- Once granted, the grant is not affected by the requester dropping req_i; d_o still follows that requester's data.
- phi0_negedge_i in CLAIM or WAIT_DRIVE: abort to IDLE, grant cleared, no drive.
- phi0_posedge_i in any non-IDLE state (missed negedge, or back-to-back cycles with short HOLD):
  - d_oe_o <= 0 and grant cleared on that edge.
  - Re-evaluate as from IDLE on the same cycle: go to CLAIM if rw_n_i=1 and enable_i=1, else go to IDLE.
- enable_i=0 in any state: go to IDLE next cycle with d_oe_o=0. conflict_count_o is retained.
- d_o holds its last value while in IDLE.

Test Plan:
- Single claim:
  - Stimulus: read cycle; req_i=4'b0100 at cnt=2; req_data_i byte2=8'hA5.
  - Required: grant_o=4'b0100; d_oe_o rises one cycle after cnt==6; d_o=8'hA5; d_oe_o falls 2 cycles after phi0_negedge; conflict_count_o stays 0.
- Conflict:
  - Stimulus: req_i=4'b1010 at cnt=1.
  - Required: grant_o=4'b0010; conflict_o pulses once; conflict_count_o=1. After 256 such cycles, conflict_count_o=255.
- Write and late claims:
  - Stimulus A: rw_n_i=0 with req_i=4'b0001. Required: busy_o stays 0, d_oe_o stays 0.
  - Stimulus B: read cycle with req_i first set at cnt=5. Required: no grant, no drive.
- Watchdog:
  - Stimulus: grant given, then no phi0_negedge for 50 cycles.
  - Required: d_oe_o drops one cycle after cnt==40; state IDLE; grant_o=0.
- Abort and restart:
  - Stimulus A: phi0_negedge_i at cnt=3 in WAIT_DRIVE. Required: IDLE, d_oe_o never rises.
  - Stimulus B: phi0_posedge_i during DRIVE. Required: d_oe_o=0 next cycle; new CLAIM entered.
- Reset and enable:
  - Stimulus A: system_reset_n_i low during DRIVE. Required: d_oe_o=0 and grant_o=0 immediately, without waiting for a clock edge.
  - Stimulus B: enable_i=0 during HOLD. Required: IDLE and d_oe_o=0 on the next edge.
